// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-cycle WIDTH-bit adder built around one 4-bit
// ripple-carry slice (add_4). Operands arrive over a valid/ready handshake,
// are added one nibble per cycle LSB first with the carry held in a flop,
// and the assembled sum is returned over a second valid/ready handshake.
//
// Optional feature macro: NIBBLE_ADD_OVF_EN
//   When defined, an extra output 'ovf' carries the signed two's-complement
//   overflow flag of the addition, valid together with out_valid.

// 4-bit ripple-carry slice shared by every nibble of the operation.
module add_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] carry;

  // Ripple the carry through the four full-adder bits.
  always_comb begin
    carry    = 5'd0;
    s        = 4'd0;
    carry[0] = ci;
    for (int i = 0; i < 4; i++) begin
      s[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    co = carry[4];
  end

endmodule

module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co
`ifdef NIBBLE_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Operand shift registers, inter-nibble carry and nibble counter.
  logic [WIDTH-1:0] a_sr, b_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  // Slice interface.
  logic [3:0]       slice_s;
  logic             slice_co;

  // Control strobes from the output decode.
  logic             accept;
  logic             step;
  logic             last_step;
  logic             in_ready_nxt;
  logic             out_valid_nxt;

  // Sum shifted one nibble down with the fresh slice nibble entering at the top.
  logic [WIDTH+3:0] sum_cat;

  add_4 u_slice (
    .a  (a_sr[3:0]),
    .b  (b_sr[3:0]),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  // State register; handshake flags are registered decodes of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = CALC;
      CALC: if (cnt == CW'(NIB - 1)) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/control decode: datapath strobes and next handshake flag values.
  always_comb begin
    accept        = 1'b0;
    step          = 1'b0;
    last_step     = 1'b0;
    in_ready_nxt  = (state_nxt == IDLE);
    out_valid_nxt = (state_nxt == DONE);
    case (state)
      IDLE: accept = in_valid;
      CALC: begin
        step      = 1'b1;
        last_step = (cnt == CW'(NIB - 1));
      end
      default: ;
    endcase
  end

  assign sum_cat = {slice_s, sum};

  // Operand capture on accept, then one nibble per CALC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      co    <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b;
      carry <= ci;
      cnt   <= '0;
    end else if (step) begin
      a_sr  <= a_sr >> 4;
      b_sr  <= b_sr >> 4;
      carry <= slice_co;
      cnt   <= cnt + CW'(1);
      sum   <= sum_cat[WIDTH+3:4];
      if (last_step) co <= slice_co;
    end
  end

`ifdef NIBBLE_ADD_OVF_EN
  logic a_msb, b_msb;

  // Capture operand sign bits and resolve signed overflow on the final nibble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (last_step) begin
      ovf   <= (a_msb == b_msb) && (slice_s[3] != a_msb);
    end
  end
`endif

  // The two handshake flags are mutually exclusive by construction.
  a_hs_exclusive : assert property (@(posedge clk) disable iff (rst) !(in_ready && out_valid));

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed testbench for nibble_serial_adder (WIDTH=16). Define
// NIBBLE_ADD_OVF_EN for both files to exercise the ovf port as well.
`timescale 1ns/1ps

module tb_nibble_serial_adder;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             co;
`ifdef NIBBLE_ADD_OVF_EN
  logic             ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .co        (co)
`ifdef NIBBLE_ADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, count latency, check result, optional stall.
  task automatic do_add(input logic [15:0] va, input logic [15:0] vb, input logic vci,
                        input logic [15:0] exp_s, input logic exp_co, input logic exp_ovf,
                        input int stall);
    int k;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    a = va; b = vb; ci = vci; in_valid = 1'b1;
    out_ready = (stall == 0);
    tick();                                   // edge E0 accepts
    in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; ci = 1'b1;    // must be ignored while busy
    check("busy_in_ready", 32'(in_ready), 32'd0);
    k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    check("latency", 32'(k), 32'(NIB));
    check("sum", 32'(sum), 32'(exp_s));
    check("co", 32'(co), 32'(exp_co));
`ifdef NIBBLE_ADD_OVF_EN
    check("ovf", 32'(ovf), 32'(exp_ovf));
`else
    if (exp_ovf) ;
`endif
    for (int i = 0; i < stall; i++) begin
      tick();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_ready", 32'(in_ready), 32'd0);
      check("stall_sum", 32'(sum), 32'(exp_s));
      check("stall_co", 32'(co), 32'(exp_co));
    end
    out_ready = 1'b1;
    tick();                                   // handshake edge
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    int e;
    logic prev;
    logic seen;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_co", 32'(co), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Basic add, carry ripple, backpressure.
    do_add(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
    do_add(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 0);
    do_add(16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 0);
    do_add(16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0, 5);

    // Reset mid-CALC discards the operation.
    a = 16'h8888; b = 16'h8888; ci = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_co", 32'(co), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_result", 32'(seen), 32'd0);
    out_ready = 1'b0;

    // Back-to-back with in_valid held: second accept NIB+2 edges after first.
    a = 16'h0001; b = 16'h0001; ci = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    tick();                                   // first accept
    a = 16'hFFFF; b = 16'h0002;
    e = 0;
    seen = 1'b0;
    prev = in_ready;
    while (e < 20) begin
      prev = in_ready;
      tick();
      e++;
      if (out_valid) begin
        seen = 1'b1;
        check("b2b1_sum", 32'(sum), 32'h0002);
        check("b2b1_co", 32'(co), 32'd0);
      end
      if (prev) break;
    end
    check("b2b1_seen", 32'(seen), 32'd1);
    check("b2b_interval", 32'(e), 32'(NIB + 2));
    in_valid = 1'b0;
    e = 0;
    while (!out_valid && e < 20) begin
      tick();
      e++;
    end
    check("b2b2_latency", 32'(e), 32'(NIB));
    check("b2b2_sum", 32'(sum), 32'h0001);
    check("b2b2_co", 32'(co), 32'd1);
    tick();
    check("b2b2_done", 32'(in_ready), 32'd1);
    out_ready = 1'b0;

`ifdef NIBBLE_ADD_OVF_EN
    do_add(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
    do_add(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0);
    do_add(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder that sits directly upstream of the 4-bit ripple-carry slice (add_4).
- Accepts a wide operand pair over a valid/ready handshake.
- Feeds the slice one nibble per cycle, LSB nibble first, and registers the slice carry between cycles.
- Assembles the WIDTH-bit sum and presents it downstream over a second valid/ready handshake.
- Trades latency for area: one 4-bit adder serves any operand width.

Parameters:
- WIDTH, 16, operand/sum width in bits. Must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, derived (localparam), nibble count per operation.

Ports:
- clk        input   1      clock, rising edge
- rst        input   1      asynchronous, active-high reset
- in_valid   input   1      operand pair valid
- in_ready   output  1      block can accept an operand pair
- a          input   WIDTH  operand A
- b          input   WIDTH  operand B
- ci         input   1      carry-in to nibble 0
- out_valid  output  1      sum/co valid
- out_ready  input   1      downstream accepts result
- sum        output  WIDTH  A+B+ci, low WIDTH bits
- co         output  1      carry out of bit WIDTH-1

Behaviour:
- Reset, applied asynchronously on rst high:
  - state=IDLE
  - in_ready=1, out_valid=0
  - sum=0, co=0
  - internal shift registers, carry register and nibble counter all 0
- FSM states: IDLE, CALC, DONE. in_ready is 1 only in IDLE. out_valid is 1 only in DONE. Both are decoded from registered state.
- IDLE:
  - On in_valid & in_ready at edge E0: capture a, b into shift registers, ci into the carry register, counter=0, go to CALC.
  - Otherwise stay in IDLE.
- CALC, each cycle:
  - Drive the slice with the low nibble of each shift register and the carry register as Ci.
  - At the clock edge:
    - shift the slice S into sum from the top (sum <= {S, sum[WIDTH-1:4]})
    - carry register <= slice Co
    - shift both operand registers right by 4
    - counter++
  - When counter==NIB-1 at the edge, also load co <= slice Co and go to DONE.
- Latency: accept at E0; last nibble written at edge E0+NIB; out_valid high from E0+NIB until handshake. For WIDTH=16, out_valid is seen high in the cycle after edge E0+4.
- DONE:
  - sum and co are held stable.
  - On out_ready at an edge, go to IDLE.
  - A new operand pair cannot be accepted in the same cycle (no bypass). The minimum issue interval is NIB+2 cycles.
- sum and co are outputs of registers only; no combinational path from inputs to outputs.
- Inputs a, b, ci are sampled only at the accepting edge. Changes while busy are ignored.
- in_valid during CALC/DONE is ignored (in_ready=0); upstream must hold it.
- out_ready during IDLE/CALC is ignored.
- Wrap-around: sum is modulo 2^WIDTH; the carry out of the top nibble appears on co only.
- Reset mid-operation: the block aborts immediately to the reset values. The partial result is discarded and no out_valid pulse is produced.
- Counter width is max(1, clog2(NIB)). When WIDTH=4, CALC lasts exactly one cycle.

Optional Feature:
- Macro: NIBBLE_ADD_OVF_EN.
- Enabled:
  - Adds output port ovf, 1 bit, with signed two's-complement overflow.
  - ovf = (a_msb == b_msb) && (sum_msb != a_msb), where a_msb and b_msb are captured at the accepting edge.
  - ovf is registered, updated on the final CALC edge together with co, and valid with out_valid.
  - ovf reset value is 0.
- Disabled:
  - No ovf port and no MSB capture flops.
  - All other behaviour is identical.

Test Plan:
- Basic add, WIDTH=16:
  - Stimulus: a=0x1234, b=0x4321, ci=0 accepted at edge E0, out_ready=1.
  - Response: out_valid rises after edge E0+4 with sum=0x5555, co=0. in_ready is 0 from E0 until return to IDLE, then 1.
- Carry ripple across nibbles:
  - Stimulus: a=0xFFFF, b=0x0000, ci=1.
  - Response: sum=0x0000, co=1.
  - Then a=0x0FFF, b=0x0001, ci=0 gives sum=0x1000, co=0.
- Backpressure:
  - Stimulus: a=0xA5A5, b=0x5A5A, ci=0 with out_ready=0 for 5 cycles after out_valid rises.
  - Response: sum=0xFFFF, co=0 held stable, out_valid=1, in_ready=0 throughout. IDLE is reached one edge after out_ready=1.
- Reset mid-CALC:
  - Stimulus: accept a=0x8888, b=0x8888, then assert rst asynchronously after 2 CALC cycles.
  - Response: sum=0, co=0, out_valid=0, in_ready=1 immediately. No result is emitted after rst drops.
- Back-to-back with input held:
  - Stimulus: in_valid held high with two pairs (0x0001+0x0001, then 0xFFFF+0x0002).
  - Response: results 0x0002/co=0, then 0x0001/co=1. The second accept occurs exactly NIB+2 edges after the first.
- With NIBBLE_ADD_OVF_EN:
  - 0x7FFF+0x0001 gives sum=0x8000, co=0, ovf=1.
  - 0x8000+0x8000 gives sum=0x0000, co=1, ovf=1.
  - 0x1234+0x4321 gives ovf=0.
